fmlprof: RTL

// - FML bus profiler; next-generation FML traffic meter. Passively taps one FML master port, no effect on traffic.
// - Counts strobe cycles, acks and write acks; measures per-transaction ack latency (sum, max).
// - Captures {we, adr} of acked transactions into a parametrised buffer: one-shot or circular mode, address-window filter.
// - CSR slave on the system CSR bus; all probe inputs registered once before use.

---
 rtl/fmlprof_pkg.sv | 38 +++
 rtl/fmlprof_capmem.sv | 37 +++
 rtl/fmlprof.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fmlprof_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fmlprof_pkg
// Purpose : Shared definitions for the FML bus profiler. Holds the CSR
//           register index map and the bit positions used in CTRL and CAP_CTL.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package fmlprof_pkg;

    // CSR register index, taken from csr_a[5:2]
    typedef enum logic [3:0] {
        REG_CTRL     = 4'd0,
        REG_STB_CYC  = 4'd1,
        REG_ACK_CNT  = 4'd2,
        REG_WACK_CNT = 4'd3,
        REG_LAT_SUM  = 4'd4,
        REG_LAT_MAX  = 4'd5,
        REG_CAP_CTL  = 4'd6,
        REG_CAP_RADR = 4'd7,
        REG_CAP_DO   = 4'd8,
        REG_FLT_BASE = 4'd9,
        REG_FLT_MASK = 4'd10
    } reg_idx_e;

    // CTRL register layout
    localparam int CTRL_W         = 3;
    localparam int CTRL_COUNT_EN  = 0;
    localparam int CTRL_CIRCULAR  = 1;
    localparam int CTRL_FILTER_EN = 2;

    // CAP_CTL register layout
    localparam int CAPCTL_STOP    = 31;  // write: 1 = stop, 0 = arm
    localparam int CAPCTL_RUNNING = 31;  // read
    localparam int CAPCTL_WRAPPED = 30;  // read

endpackage : fmlprof_pkg
`default_nettype wire

// File: rtl/fmlprof_capmem.sv
`default_nettype none
// ============================================================================
// Module  : fmlprof_capmem
// Purpose : Single-port synchronous capture RAM with registered read data.
//           Read-before-write; the array itself carries no reset.
// Ports   : clk      - clock
//           i_we     - write enable
//           i_addr   - shared read/write address
//           i_wdata  - write data
//           o_rdata  - registered read data (mem[i_addr] of previous cycle)
// Revision: 1.0 - initial release
// ============================================================================
module fmlprof_capmem #(
    parameter int WIDTH = 27,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wdata;
        end
        rdata_q <= mem[i_addr];
    end

    assign o_rdata = rdata_q;

endmodule : fmlprof_capmem
`default_nettype wire

// File: rtl/fmlprof.sv
`default_nettype none
// ============================================================================
// Module  : fmlprof
// Purpose : Passive FML bus profiler. Counts strobe cycles, acks and write
//           acks, tracks per-transaction ack latency (sum/max) and captures
//           {we, adr} of acked transactions into a one-shot or circular
//           buffer with an optional address-window filter. CSR slave.
// Ports   : sys_clk, sys_rst_n        - clock, async active-low reset
//           csr_a/csr_we/csr_di       - CSR address, write strobe, write data
//           csr_do                    - registered CSR read data
//           fml_stb/ack/we/adr        - probed FML master signals (inputs only)
// Revision: 1.0 - initial release
// ============================================================================
module fmlprof
    import fmlprof_pkg::*;
#(
    parameter logic [4:0] csr_addr  = 5'h0,
    parameter int         fml_depth = 26,
    parameter int         cap_aw    = 12,
    parameter int         lat_width = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [14:0]          csr_a,
    input  logic                 csr_we,
    input  logic [31:0]          csr_di,
    output logic [31:0]          csr_do,
    input  logic                 fml_stb,
    input  logic                 fml_ack,
    input  logic                 fml_we,
    input  logic [fml_depth-1:0] fml_adr
);

    // ---------------- state ----------------
    logic                 stb_q, ack_q, we_q;
    logic [fml_depth-1:0] adr_q;
    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [31:0]          stb_cyc_q, stb_cyc_d, ack_cnt_q, ack_cnt_d;
    logic [31:0]          wack_cnt_q, wack_cnt_d, lat_sum_q, lat_sum_d;
    logic [lat_width-1:0] lat_q, lat_d, lat_max_q, lat_max_d;
    logic                 in_txn_q, in_txn_d;
    logic                 running_q, running_d, wrapped_q, wrapped_d;
    logic [cap_aw-1:0]    wadr_q, wadr_d, radr_q, radr_d;
    logic [fml_depth-1:0] flt_base_q, flt_base_d, flt_mask_q, flt_mask_d;
    logic [31:0]          csr_do_q, csr_do_d;

    // ---------------- combinational ----------------
    logic                 csr_sel, csr_wr, ctrl_wr, capctl_wr, cnt_clr;
    logic [3:0]           csr_idx;
    logic                 txn_start;
    logic [lat_width-1:0] lat_inc, lat_cur;
    logic                 flt_hit, cap_ev;
    logic [cap_aw-1:0]    mem_addr;
    logic [fml_depth:0]   mem_rdata;
    logic                 unused_bits;

    assign unused_bits = ^{csr_a, csr_di};

    // CSR decode
    always_comb begin
        csr_sel   = (csr_a[14:10] == csr_addr);
        csr_idx   = csr_a[5:2];
        csr_wr    = csr_we & csr_sel;
        ctrl_wr   = csr_wr & (csr_idx == REG_CTRL);
        capctl_wr = csr_wr & (csr_idx == REG_CAP_CTL);
        // Writing CTRL with bit 0 set both enables counting and zeroes stats
        cnt_clr   = ctrl_wr & csr_di[CTRL_COUNT_EN];

        ctrl_d     = ctrl_wr ? csr_di[CTRL_W-1:0] : ctrl_q;
        radr_d     = (csr_wr && csr_idx == REG_CAP_RADR) ? csr_di[cap_aw-1:0] : radr_q;
        flt_base_d = (csr_wr && csr_idx == REG_FLT_BASE) ? csr_di[fml_depth-1:0] : flt_base_q;
        flt_mask_d = (csr_wr && csr_idx == REG_FLT_MASK) ? csr_di[fml_depth-1:0] : flt_mask_q;
    end

    // Latency tracker and event counters. lat_cur is the latency of the
    // current cycle counted inclusively, so an ack on the first strobe
    // cycle reports 1.
    always_comb begin
        txn_start = stb_q & ~in_txn_q;
        lat_inc   = (lat_q == '1) ? lat_q : lat_q + lat_width'(1);
        lat_cur   = txn_start ? lat_width'(1) : lat_inc;

        lat_d    = (txn_start | in_txn_q) ? lat_cur : lat_q;
        in_txn_d = (in_txn_q | txn_start) & ~ack_q;

        stb_cyc_d  = stb_cyc_q;
        ack_cnt_d  = ack_cnt_q;
        wack_cnt_d = wack_cnt_q;
        lat_sum_d  = lat_sum_q;
        lat_max_d  = lat_max_q;
        if (cnt_clr) begin
            stb_cyc_d  = '0;
            ack_cnt_d  = '0;
            wack_cnt_d = '0;
            lat_sum_d  = '0;
            lat_max_d  = '0;
        end else if (ctrl_q[CTRL_COUNT_EN]) begin
            if (stb_q) stb_cyc_d = stb_cyc_q + 32'd1;
            if (ack_q) begin
                ack_cnt_d = ack_cnt_q + 32'd1;
                if (we_q) wack_cnt_d = wack_cnt_q + 32'd1;
                lat_sum_d = lat_sum_q + 32'(lat_cur);
                if (lat_cur > lat_max_q) lat_max_d = lat_cur;
            end
        end
    end

    // Capture pointer control. A CAP_CTL write in the same cycle suppresses
    // the capture event entirely (no RAM write, no pointer move).
    always_comb begin
        flt_hit = ~ctrl_q[CTRL_FILTER_EN] |
                  (((adr_q ^ flt_base_q) & flt_mask_q) == '0);
        cap_ev  = running_q & stb_q & ack_q & flt_hit & ~capctl_wr;

        running_d = running_q;
        wrapped_d = wrapped_q;
        wadr_d    = wadr_q;
        if (capctl_wr) begin
            if (csr_di[CAPCTL_STOP]) begin
                running_d = 1'b0;
            end else begin
                running_d = 1'b1;
                wrapped_d = 1'b0;
                wadr_d    = '0;
            end
        end else if (cap_ev) begin
            if (wadr_q == '1) begin
                if (ctrl_q[CTRL_CIRCULAR]) begin
                    wadr_d    = '0;
                    wrapped_d = 1'b1;
                end else begin
                    // one-shot: last entry written, pointer parks on it
                    running_d = 1'b0;
                end
            end else begin
                wadr_d = wadr_q + cap_aw'(1);
            end
        end
        mem_addr = cap_ev ? wadr_q : radr_q;
    end

    fmlprof_capmem #(
        .WIDTH (fml_depth + 1),
        .AW    (cap_aw)
    ) u_capmem (
        .clk     (sys_clk),
        .i_we    (cap_ev),
        .i_addr  (mem_addr),
        .i_wdata ({we_q, adr_q}),
        .o_rdata (mem_rdata)
    );

    // CSR read mux
    always_comb begin
        csr_do_d = '0;
        if (csr_sel) begin
            case (csr_idx)
                REG_CTRL:     csr_do_d[CTRL_W-1:0] = ctrl_q;
                REG_STB_CYC:  csr_do_d = stb_cyc_q;
                REG_ACK_CNT:  csr_do_d = ack_cnt_q;
                REG_WACK_CNT: csr_do_d = wack_cnt_q;
                REG_LAT_SUM:  csr_do_d = lat_sum_q;
                REG_LAT_MAX:  csr_do_d[lat_width-1:0] = lat_max_q;
                REG_CAP_CTL: begin
                    csr_do_d[CAPCTL_RUNNING] = running_q;
                    csr_do_d[CAPCTL_WRAPPED] = wrapped_q;
                    csr_do_d[cap_aw-1:0]     = wadr_q;
                end
                REG_CAP_RADR: csr_do_d[cap_aw-1:0]    = radr_q;
                REG_CAP_DO:   csr_do_d[fml_depth:0]   = mem_rdata;
                REG_FLT_BASE: csr_do_d[fml_depth-1:0] = flt_base_q;
                REG_FLT_MASK: csr_do_d[fml_depth-1:0] = flt_mask_q;
                default:      csr_do_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stb_q      <= 1'b0;
            ack_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            ctrl_q     <= '0;
            stb_cyc_q  <= '0;
            ack_cnt_q  <= '0;
            wack_cnt_q <= '0;
            lat_sum_q  <= '0;
            lat_max_q  <= '0;
            lat_q      <= '0;
            in_txn_q   <= 1'b0;
            running_q  <= 1'b0;
            wrapped_q  <= 1'b0;
            wadr_q     <= '0;
            radr_q     <= '0;
            flt_base_q <= '0;
            flt_mask_q <= '0;
            csr_do_q   <= '0;
        end else begin
            stb_q      <= fml_stb;
            ack_q      <= fml_ack;
            we_q       <= fml_we;
            adr_q      <= fml_adr;
            ctrl_q     <= ctrl_d;
            stb_cyc_q  <= stb_cyc_d;
            ack_cnt_q  <= ack_cnt_d;
            wack_cnt_q <= wack_cnt_d;
            lat_sum_q  <= lat_sum_d;
            lat_max_q  <= lat_max_d;
            lat_q      <= lat_d;
            in_txn_q   <= in_txn_d;
            running_q  <= running_d;
            wrapped_q  <= wrapped_d;
            wadr_q     <= wadr_d;
            radr_q     <= radr_d;
            flt_base_q <= flt_base_d;
            flt_mask_q <= flt_mask_d;
            csr_do_q   <= csr_do_d;
        end
    end

    assign csr_do = csr_do_q;

endmodule : fmlprof
`default_nettype wire
